// File: rtl/crit_arb_pkg.sv
// rtl/crit_arb_pkg.sv - shared types and defaults for the critical-path arbiter
// Purpose: arbiter state encoding, default parameter values and the RR pointer
// advance helper used by crit_path_arbiter and its testbench.
package crit_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_FORCE = 2'd2
    } arb_state_e;

    localparam int DEF_NUM_REQ      = 4;
    localparam int DEF_DATA_W       = 8;
    localparam int DEF_HOLD_CYCLES  = 4;
    localparam int DEF_STARVE_LIMIT = 8;

    // Pointer value after granting idx: one past the winner, wrapping at n.
    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/crit_path_arbiter_rr_pick.sv
// rtl/crit_path_arbiter_rr_pick.sv - round-robin picker for one request class
// Purpose: returns the first set bit of req at or after ptr, with wrap.
// Ports:
//   req  in  N      candidate requests of one class
//   ptr  in  IDX_W  search start index (always < N)
//   gnt  out N      one-hot winner, zero when req is empty
//   idx  out IDX_W  binary index of the winner
//   any  out 1      req is non-empty
module rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // Walk from the farthest offset towards ptr so the nearest hit overwrites.
    always_comb begin
        int j;
        j   = 0;
        gnt = '0;
        idx = '0;
        any = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            j = (int'(ptr) + k) % N;
            if (req[j]) begin
                gnt    = '0;
                gnt[j] = 1'b1;
                idx    = IDX_W'(j);
                any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/crit_path_arbiter.sv
// rtl/crit_path_arbiter.sv - critical/non-critical arbiter with starvation guard
// Purpose: selects which requester drives the registered output datapath.
// Critical requests preempt non-critical tenures, round-robin within each class,
// tenures are bounded by HOLD_CYCLES when contended, and a starvation counter
// forces a non-preemptible non-critical tenure after STARVE_LIMIT cycles.
// Ports:
//   clk, rst   clock and asynchronous active-high reset
//   req, crit  per-requester level request and class (1 = critical)
//   data       packed requester data, requester i at [i*DATA_W +: DATA_W]
//   gnt        registered one-hot grant
//   out_data   registered data of the granted requester (holds when invalid)
//   out_valid  out_data was captured from a live grant this cycle
//   busy       arbiter is not idle
//   forced     current tenure is a starvation-forced non-critical grant
module crit_path_arbiter
    import crit_arb_pkg::*;
#(
    parameter int NUM_REQ      = DEF_NUM_REQ,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int HOLD_CYCLES  = DEF_HOLD_CYCLES,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        crit,
    input  logic [NUM_REQ*DATA_W-1:0] data,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [DATA_W-1:0]         out_data,
    output logic                      out_valid,
    output logic                      busy,
    output logic                      forced
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TEN_W = $clog2(HOLD_CYCLES + 1);
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);

    arb_state_e          state_q, state_d;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d;
    logic [IDX_W-1:0]    owner_q, owner_d;
    logic                owner_crit_q, owner_crit_d;
    logic [TEN_W-1:0]    tenure_q, tenure_d;
    logic [STV_W-1:0]    starve_q, starve_d;
    logic [IDX_W-1:0]    ptr_c_q, ptr_c_d;
    logic [IDX_W-1:0]    ptr_n_q, ptr_n_d;
    logic                forced_q, forced_d;
    logic                out_valid_q, out_valid_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;

    logic [NUM_REQ-1:0]  excl, c_set, n_set, c_gnt, n_gnt;
    logic [IDX_W-1:0]    c_idx, n_idx;
    logic                c_any, n_any;
    logic                owner_live, expired, starve_hit;
    logic [STV_W-1:0]    starve_now;
    logic                take_c, take_n, take_f, go_idle;

    // In GRANT the owner is removed from both sets: its latched class governs
    // the tenure, and expiry rearbitration must pick someone else.
    assign excl       = (state_q == ST_GRANT) ? gnt_q : '0;
    assign c_set      = req & crit & ~excl;
    assign n_set      = req & ~crit & ~excl;
    assign owner_live = |(gnt_q & req);
    assign expired    = (tenure_q == TEN_W'(HOLD_CYCLES - 1));

    rr_pick #(.N(NUM_REQ), .IDX_W(IDX_W)) u_pick_c (
        .req (c_set),
        .ptr (ptr_c_q),
        .gnt (c_gnt),
        .idx (c_idx),
        .any (c_any)
    );

    rr_pick #(.N(NUM_REQ), .IDX_W(IDX_W)) u_pick_n (
        .req (n_set),
        .ptr (ptr_n_q),
        .gnt (n_gnt),
        .idx (n_idx),
        .any (n_any)
    );

    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        owner_d      = owner_q;
        owner_crit_d = owner_crit_q;
        tenure_d     = tenure_q;
        ptr_c_d      = ptr_c_q;
        ptr_n_d      = ptr_n_q;
        forced_d     = forced_q;
        take_c       = 1'b0;
        take_n       = 1'b0;
        take_f       = 1'b0;
        go_idle      = 1'b0;

        // Starvation count including this cycle; saturates at the limit.
        starve_now = '0;
        if (state_q == ST_GRANT && owner_crit_q && n_any) begin
            starve_now = (starve_q == STV_W'(STARVE_LIMIT)) ? starve_q
                                                             : starve_q + 1'b1;
        end
        starve_d   = starve_now;
        starve_hit = (starve_now == STV_W'(STARVE_LIMIT));

        case (state_q)
            ST_IDLE: begin
                if (c_any)      take_c = 1'b1;
                else if (n_any) take_n = 1'b1;
            end
            ST_GRANT: begin
                if (!owner_live) begin
                    if (starve_hit)  take_f  = 1'b1;
                    else if (c_any)  take_c  = 1'b1;
                    else if (n_any)  take_n  = 1'b1;
                    else             go_idle = 1'b1;
                end else if (!owner_crit_q && c_any) begin
                    take_c = 1'b1;
                end else if (expired) begin
                    if (starve_hit)                  take_f = 1'b1;
                    else if (c_any)                  take_c = 1'b1;
                    else if (!owner_crit_q && n_any) take_n = 1'b1;
                    else                             tenure_d = '0;
                end else begin
                    tenure_d = tenure_q + 1'b1;
                end
            end
            ST_FORCE: begin
                if (!owner_live || expired) begin
                    if (c_any)      take_c  = 1'b1;
                    else if (n_any) take_n  = 1'b1;
                    else            go_idle = 1'b1;
                end else begin
                    tenure_d = tenure_q + 1'b1;
                end
            end
            default: go_idle = 1'b1;
        endcase

        if (take_c) begin
            state_d      = ST_GRANT;
            gnt_d        = c_gnt;
            owner_d      = c_idx;
            owner_crit_d = 1'b1;
            tenure_d     = '0;
            forced_d     = 1'b0;
            ptr_c_d      = IDX_W'(rr_next(int'(c_idx), NUM_REQ));
        end else if (take_n || take_f) begin
            state_d      = take_f ? ST_FORCE : ST_GRANT;
            gnt_d        = n_gnt;
            owner_d      = n_idx;
            owner_crit_d = 1'b0;
            tenure_d     = '0;
            forced_d     = take_f;
            ptr_n_d      = IDX_W'(rr_next(int'(n_idx), NUM_REQ));
            starve_d     = '0;
        end else if (go_idle) begin
            state_d      = ST_IDLE;
            gnt_d        = '0;
            owner_crit_d = 1'b0;
            tenure_d     = '0;
            forced_d     = 1'b0;
        end
    end

    // Output stage follows the grant that is live during this cycle.
    always_comb begin
        out_valid_d = owner_live;
        out_data_d  = out_data_q;
        if (owner_live) begin
            out_data_d = data[int'(owner_q) * DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            gnt_q        <= '0;
            owner_q      <= '0;
            owner_crit_q <= 1'b0;
            tenure_q     <= '0;
            starve_q     <= '0;
            ptr_c_q      <= '0;
            ptr_n_q      <= '0;
            forced_q     <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            owner_q      <= owner_d;
            owner_crit_q <= owner_crit_d;
            tenure_q     <= tenure_d;
            starve_q     <= starve_d;
            ptr_c_q      <= ptr_c_d;
            ptr_n_q      <= ptr_n_d;
            forced_q     <= forced_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
        end
    end

    assign gnt       = gnt_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign busy      = (state_q != ST_IDLE);
    assign forced    = forced_q;

endmodule

// File: tb/tb_crit_path_arbiter.sv
// tb/tb_crit_path_arbiter.sv - self-checking bench for crit_path_arbiter
module tb_crit_path_arbiter;

    localparam int NR   = 4;
    localparam int DW   = 8;
    localparam int HOLD = 4;
    localparam int SL   = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic [NR-1:0]  req, crit;
    logic [NR*DW-1:0] data;
    logic [NR-1:0]  gnt;
    logic [DW-1:0]  out_data;
    logic           out_valid, busy, forced;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    crit_path_arbiter #(
        .NUM_REQ      (NR),
        .DATA_W       (DW),
        .HOLD_CYCLES  (HOLD),
        .STARVE_LIMIT (SL)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .crit      (crit),
        .data      (data),
        .gnt       (gnt),
        .out_data  (out_data),
        .out_valid (out_valid),
        .busy      (busy),
        .forced    (forced)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        req  = '0;
        crit = '0;
        data = '0;
        rst  = 1'b1;
        @(negedge clk);
        rst  = 1'b0;
    endtask

    // Reference model: owner index (-1 idle), latched class, forced flag,
    // cycles held in the current tenure, cycles critical traffic has blocked
    // non-critical traffic, and one RR pointer per class.
    int            m_own, m_held, m_starve, m_pc, m_pn;
    bit            m_oc, m_force, m_ov;
    logic [DW-1:0] m_od;

    function automatic int pick(input logic [NR-1:0] s, input int p);
        for (int k = 0; k < NR; k++)
            if (s[(p + k) % NR]) return (p + k) % NR;
        return -1;
    endfunction

    task automatic m_reset();
        m_own = -1; m_held = 0; m_starve = 0; m_pc = 0; m_pn = 0;
        m_oc = 0; m_force = 0; m_ov = 0; m_od = '0;
    endtask

    task automatic m_grant(input int w, input bit cls, input bit frc);
        m_own = w; m_oc = cls; m_force = frc; m_held = 1;
        if (cls) m_pc = (w + 1) % NR;
        else begin
            m_pn = (w + 1) % NR;
            m_starve = 0;
        end
    endtask

    task automatic m_arb(input logic [NR-1:0] cs, input logic [NR-1:0] ns);
        int wc, wn;
        wc = pick(cs, m_pc);
        wn = pick(ns, m_pn);
        if (wc >= 0)      m_grant(wc, 1'b1, 1'b0);
        else if (wn >= 0) m_grant(wn, 1'b0, 1'b0);
        else begin
            m_own = -1; m_force = 0;
        end
    endtask

    task automatic m_step();
        logic [NR-1:0] cs, ns;
        bit drop, expire, starved;
        cs = req & crit;
        ns = req & ~crit;
        m_ov = (m_own >= 0) && req[m_own];
        if (m_ov) m_od = data[m_own*DW +: DW];
        if (m_own < 0) begin
            m_starve = 0;
            m_arb(cs, ns);
        end else if (m_force) begin
            drop   = !req[m_own];
            expire = (m_held == HOLD);
            if (drop || expire) begin
                m_starve = 0;
                m_arb(cs, ns);
            end else m_held++;
        end else begin
            drop   = !req[m_own];
            expire = (m_held == HOLD);
            cs[m_own] = 1'b0;
            ns[m_own] = 1'b0;
            if (m_oc && ns != 0) m_starve++;
            else m_starve = 0;
            starved = (m_starve >= SL);
            if (drop) begin
                if (starved) m_grant(pick(ns, m_pn), 1'b0, 1'b1);
                else m_arb(cs, ns);
            end else if (!m_oc && cs != 0) begin
                m_grant(pick(cs, m_pc), 1'b1, 1'b0);
            end else if (expire) begin
                if (starved) m_grant(pick(ns, m_pn), 1'b0, 1'b1);
                else if (cs != 0 || (!m_oc && ns != 0)) m_arb(cs, ns);
                else m_held = 1;
            end else m_held++;
        end
    endtask

    initial begin
        logic [31:0] eg;

        // Reset state
        do_reset();
        check("rst_gnt", 32'(gnt), 32'h0);
        check("rst_valid", 32'(out_valid), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_forced", 32'(forced), 32'h0);
        check("rst_data", 32'(out_data), 32'h0);

        // Asynchronous reset mid-tenure, then restart latency
        req = 4'b0010;
        data = 32'h44332211;
        @(negedge clk);
        check("t1_gnt_pre", 32'(gnt), 32'h2);
        @(negedge clk);
        check("t1_valid_pre", 32'(out_valid), 32'h1);
        #2 rst = 1'b1;
        #1;
        check("t1_async_gnt", 32'(gnt), 32'h0);
        check("t1_async_valid", 32'(out_valid), 32'h0);
        check("t1_async_forced", 32'(forced), 32'h0);
        check("t1_async_busy", 32'(busy), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        req = 4'b0001;
        @(negedge clk);
        check("t1_gnt", 32'(gnt), 32'h1);
        check("t1_valid_lat", 32'(out_valid), 32'h0);
        @(negedge clk);
        check("t1_valid", 32'(out_valid), 32'h1);
        check("t1_data", 32'(out_data), 32'h11);

        // Critical preemption without a bubble
        req  = 4'b0101;
        crit = 4'b0100;
        @(negedge clk);
        check("t2_gnt", 32'(gnt), 32'h4);
        check("t2_valid", 32'(out_valid), 32'h1);
        @(negedge clk);
        check("t2_data", 32'(out_data), 32'h33);

        // Round-robin fairness among non-critical requesters
        do_reset();
        req = 4'b1111;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            eg = 32'h1 << ((k / HOLD) % NR);
            check($sformatf("t3_gnt_%0d", k), 32'(gnt), eg);
        end

        // Starvation guard: forced non-critical tenure, then back to critical
        do_reset();
        req  = 4'b0011;
        crit = 4'b0001;
        for (int k = 1; k <= 13; k++) begin
            @(negedge clk);
            eg = (k >= SL + 1 && k <= SL + HOLD) ? 32'h2 : 32'h1;
            check($sformatf("t4_gnt_%0d", k), 32'(gnt), eg);
            check($sformatf("t4_forced_%0d", k), 32'(forced), (eg == 32'h2) ? 32'h1 : 32'h0);
        end

        // Owner drop with simultaneous critical arrival
        do_reset();
        req = 4'b0101;
        @(negedge clk);
        check("t5_gnt_pre", 32'(gnt), 32'h1);
        req  = 4'b1100;
        crit = 4'b1000;
        @(negedge clk);
        check("t5_gnt", 32'(gnt), 32'h8);

        // Return to idle, out_data holds
        do_reset();
        req  = 4'b0100;
        data = 32'h00A50000;
        @(negedge clk);
        check("t6_gnt", 32'(gnt), 32'h4);
        @(negedge clk);
        check("t6_valid", 32'(out_valid), 32'h1);
        check("t6_data", 32'(out_data), 32'hA5);
        req  = 4'b0000;
        data = 32'hFFFFFFFF;
        @(negedge clk);
        check("t6_idle_gnt", 32'(gnt), 32'h0);
        check("t6_idle_busy", 32'(busy), 32'h0);
        @(negedge clk);
        check("t6_idle_valid", 32'(out_valid), 32'h0);
        check("t6_hold_data", 32'(out_data), 32'hA5);

        // Randomized traffic against the reference model
        do_reset();
        m_reset();
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NR; i++) begin
                if ($urandom_range(0, 4) == 0) req[i] = ~req[i];
                if ($urandom_range(0, 7) == 0) crit[i] = 1'($urandom_range(0, 1));
            end
            data = $urandom;
            @(posedge clk);
            m_step();
            @(negedge clk);
            eg = (m_own >= 0) ? (32'h1 << m_own) : 32'h0;
            check($sformatf("rnd_gnt_%0d", c), 32'(gnt), eg);
            check($sformatf("rnd_valid_%0d", c), 32'(out_valid), 32'(m_ov));
            check($sformatf("rnd_data_%0d", c), 32'(out_data), 32'(m_od));
            check($sformatf("rnd_forced_%0d", c), 32'(forced), 32'(m_force && m_own >= 0));
            check($sformatf("rnd_busy_%0d", c), 32'(busy), 32'(m_own >= 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
